// File: rtl/bp_pkg.sv
// Shared types and constants for the BP map player: cell and move encodings, verdict codes, map geometry.
package bp_pkg;

  typedef enum logic [1:0] {ROAD = 2'd0, LOW = 2'd1, HIGH = 2'd2, WALL = 2'd3} cell_e;
  typedef enum logic [1:0] {STAY = 2'd0, RIGHT = 2'd1, LEFT = 2'd2, JUMP = 2'd3} move_e;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_WALL    = 3'd1;
  localparam logic [2:0] ERR_JUMP    = 3'd2;
  localparam logic [2:0] ERR_EDGE    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_DROP    = 3'd5;
  localparam logic [2:0] ERR_OVERLAP = 3'd6;

  localparam int ROWS        = 64;
  localparam int MOVES       = 63;
  localparam int OBST_PERIOD = 8;

  // Type code 3 would be a second wall, so it folds back to plain road.
  function automatic logic [1:0] gap_type(input logic [1:0] b);
    return (b == 2'd3) ? 2'd0 : b;
  endfunction

endpackage

// File: rtl/bp_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous load and single-step advance.
// Latency: new value visible the cycle after load/step; no backpressure.
module bp_lfsr16 #(
  parameter logic [15:0] RST_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_value = r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= RST_VAL;
    end else if (i_load) begin
      r_lfsr <= i_seed;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule

// File: rtl/bp_map_player.sv
// Drives a seeded 64-row BP obstacle map, then replays the 63-move answer and scores it.
// Latency: 64-cycle map burst, verdict one cycle after the deciding move; the responder cannot stall the map.
module bp_map_player
  import bp_pkg::*;
#(
  parameter int          TIMEOUT  = 300,
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        in_valid,
  output logic [2:0]  guy,
  output logic [1:0]  in0,
  output logic [1:0]  in1,
  output logic [1:0]  in2,
  output logic [1:0]  in3,
  output logic [1:0]  in4,
  output logic [1:0]  in5,
  output logic [1:0]  in6,
  output logic [1:0]  in7,
  input  logic        out_valid,
  input  logic [1:0]  out,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_step,
  output logic [2:0]  err_code
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]      r_state;
  logic [5:0]      r_d;
  logic [5:0]      r_mv;
  logic [TW-1:0]   r_to;
  logic [2:0]      r_lane;
  logic [7:0][2:0] r_gap_lane;
  logic [7:0][1:0] r_gap_type;
  logic [7:0][1:0] r_row;
  logic            r_valid;
  logic [2:0]      r_guy;
  logic            r_done;
  logic            r_pass;
  logic [5:0]      r_err_step;
  logic [2:0]      r_err_code;

  logic [15:0]     w_seed_eff;
  logic [15:0]     w_lfsr;
  logic            w_load;
  logic            w_step;
  logic [5:0]      w_nd;
  logic [1:0]      w_gtype;
  logic [7:0][1:0] w_obst_row;
  logic [5:0]      w_row;
  logic [2:0]      w_ridx;
  logic            w_obst;
  move_e           w_move;
  logic [2:0]      w_nlane;
  logic            w_edge;
  logic            w_wall;
  logic            w_jmp;
  logic [2:0]      w_code;
  logic            w_fin;
  logic [2:0]      w_fin_code;
  logic [5:0]      w_fin_step;
  logic            w_unused_lfsr;

  assign w_seed_eff = (seed == 16'd0) ? DEF_SEED : seed;
  assign w_load     = (r_state == S_IDLE) && start;
  assign w_nd       = r_d + 6'd1;
  // Step one row ahead so each obstacle row registers straight from the current LFSR value.
  assign w_step     = (r_state == S_DRIVE) && (w_nd[2:0] == 3'd7) && (w_nd != 6'(ROWS - 1));

  bp_lfsr16 #(.RST_VAL(DEF_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_seed  (w_seed_eff),
    .i_step  (w_step),
    .o_value (w_lfsr)
  );

  assign w_gtype       = gap_type(w_lfsr[4:3]);
  assign w_unused_lfsr = ^w_lfsr[15:5];

  always_comb begin
    w_obst_row = '0;
    for (int i = 0; i < 8; i++) begin
      w_obst_row[i] = (3'(i) == w_lfsr[2:0]) ? w_gtype : WALL;
    end
  end

  // Move k lands on row k+1; obstacle tables are indexed by row/8.
  assign w_row  = r_mv + 6'd1;
  assign w_ridx = w_row[5:3];
  assign w_obst = (w_row[2:0] == 3'd0);
  assign w_move = move_e'(out);

  always_comb begin
    w_edge  = 1'b0;
    w_nlane = r_lane;
    case (w_move)
      RIGHT: if (r_lane == 3'd7) w_edge = 1'b1; else w_nlane = r_lane + 3'd1;
      LEFT:  if (r_lane == 3'd0) w_edge = 1'b1; else w_nlane = r_lane - 3'd1;
      default: ;
    endcase
  end

  assign w_wall = w_obst && (w_nlane != r_gap_lane[w_ridx]);
  assign w_jmp  = w_obst && (((r_gap_type[w_ridx] == LOW)  && (w_move != JUMP)) ||
                             ((r_gap_type[w_ridx] == HIGH) && (w_move == JUMP)));
  assign w_code = w_edge ? ERR_EDGE : (w_wall ? ERR_WALL : (w_jmp ? ERR_JUMP : ERR_OK));

  always_comb begin
    w_fin      = 1'b0;
    w_fin_code = ERR_OK;
    w_fin_step = 6'd0;
    case (r_state)
      S_DRIVE: if (out_valid) begin
        w_fin = 1'b1; w_fin_code = ERR_OVERLAP;
      end
      S_WAIT: begin
        if (out_valid) begin
          if (w_code != ERR_OK) begin
            w_fin = 1'b1; w_fin_code = w_code; w_fin_step = r_mv;
          end
        end else if (r_to == TO_LAST) begin
          w_fin = 1'b1; w_fin_code = ERR_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (!out_valid) begin
          w_fin = 1'b1; w_fin_code = ERR_DROP; w_fin_step = r_mv;
        end else if (w_code != ERR_OK) begin
          w_fin = 1'b1; w_fin_code = w_code; w_fin_step = r_mv;
        end else if (r_mv == 6'(MOVES - 1)) begin
          w_fin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;    r_d <= '0;        r_mv <= '0;
      r_to <= '0;           r_lane <= '0;     r_gap_lane <= '0;
      r_gap_type <= '0;     r_row <= '0;      r_valid <= 1'b0;
      r_guy <= '0;          r_done <= 1'b0;   r_pass <= 1'b0;
      r_err_step <= '0;     r_err_code <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_fin) begin
        r_state    <= S_REPORT;
        r_done     <= 1'b1;
        r_pass     <= (w_fin_code == ERR_OK);
        r_err_code <= w_fin_code;
        r_err_step <= w_fin_step;
        r_valid    <= 1'b0;
        r_row      <= '0;
        r_guy      <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_state    <= S_DRIVE;
            r_d        <= '0;
            r_mv       <= '0;
            r_valid    <= 1'b1;
            r_row      <= '0;
            r_guy      <= w_seed_eff[2:0];
            r_lane     <= w_seed_eff[2:0];
            r_pass     <= 1'b0;
            r_err_step <= '0;
            r_err_code <= ERR_OK;
          end
          S_DRIVE: begin
            r_guy <= '0;
            if (r_d == 6'(ROWS - 1)) begin
              r_valid <= 1'b0;
              r_row   <= '0;
              r_to    <= '0;
              r_state <= S_WAIT;
            end else begin
              r_d <= w_nd;
              if (w_nd[2:0] == 3'd0) begin
                r_row                <= w_obst_row;
                r_gap_lane[w_nd[5:3]] <= w_lfsr[2:0];
                r_gap_type[w_nd[5:3]] <= w_gtype;
              end else begin
                r_row <= '0;
              end
            end
          end
          S_WAIT: begin
            if (out_valid) begin
              r_lane  <= w_nlane;
              r_mv    <= 6'd1;
              r_state <= S_CHECK;
            end else begin
              r_to <= r_to + 1'b1;
            end
          end
          S_CHECK: begin
            r_lane <= w_nlane;
            r_mv   <= r_mv + 6'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_valid = r_valid;
  assign guy      = r_guy;
  assign in0      = r_row[0];
  assign in1      = r_row[1];
  assign in2      = r_row[2];
  assign in3      = r_row[3];
  assign in4      = r_row[4];
  assign in5      = r_row[5];
  assign in6      = r_row[6];
  assign in7      = r_row[7];
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_step = r_err_step;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_bp_map_player.sv
// Directed bench for bp_map_player: golden, stay-only, silent and dropping responders, reset abort, seed 0.
module tb_bp_map_player;

  localparam int M_GOLD = 0;
  localparam int M_STAY = 1;
  localparam int M_MUTE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        out_valid = 1'b0;
  logic [1:0]  out = 2'd0;
  logic        in_valid, done, pass;
  logic [2:0]  guy, err_code;
  logic [1:0]  in0, in1, in2, in3, in4, in5, in6, in7;
  logic [5:0]  err_step;

  int total = 0;
  int bad   = 0;

  logic [2:0]  m_gl [8];
  logic [1:0]  m_gt [8];
  logic [2:0]  m_guy;
  logic [15:0] cap [64];
  logic [2:0]  cap_guy [64];
  int          iv_cnt, done_cnt, t_done, iv_extra;
  logic        v_pass, done_after;
  logic [2:0]  v_code;
  logic [5:0]  v_step;

  bp_map_player dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .in_valid(in_valid), .guy(guy),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .out_valid(out_valid), .out(out),
    .done(done), .pass(pass), .err_step(err_step), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic fill_model(input logic [15:0] sd);
    logic [15:0] v;
    v = (sd == 16'd0) ? 16'hACE1 : sd;
    m_guy = v[2:0];
    m_gl[0] = 3'd0;
    m_gt[0] = 2'd0;
    for (int i = 1; i < 8; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      m_gl[i] = v[2:0];
      m_gt[i] = (v[4:3] == 2'd3) ? 2'd0 : v[4:3];
    end
  endtask

  function automatic logic [15:0] row_exp(input int d);
    logic [15:0] r;
    r = '0;
    if (d > 0 && d < 64 && d % 8 == 0)
      for (int i = 0; i < 8; i++)
        r[2*i +: 2] = (3'(i) == m_gl[d/8]) ? m_gt[d/8] : 2'd3;
    return r;
  endfunction

  task automatic check_map(input string tag);
    for (int d = 0; d < 64; d++) begin
      chk($sformatf("%s_row%0d", tag, d), cap[d], row_exp(d));
      chk($sformatf("%s_guy%0d", tag, d), cap_guy[d], (d == 0) ? m_guy : 3'd0);
    end
  endtask

  task automatic run(input logic [15:0] sd, input int mode, input int drop_at, input int start_at);
    int k, t, j;
    logic [2:0] lane;
    k = 0; t = -1;
    fill_model(sd);
    lane = m_guy;
    iv_cnt = 0; done_cnt = 0; t_done = -1; iv_extra = 0; done_after = 1'b0;
    v_pass = 1'b0; v_code = 3'd7; v_step = 6'h3f;
    seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 1000 && done_cnt == 0; c++) begin
      if (in_valid) begin
        if (iv_cnt < 64) begin
          cap[iv_cnt] = {in7, in6, in5, in4, in3, in2, in1, in0};
          cap_guy[iv_cnt] = guy;
        end
        iv_cnt++;
      end else if (iv_cnt > 0) begin
        t++;
      end
      if (done) begin
        done_cnt++; t_done = t;
        v_pass = pass; v_code = err_code; v_step = err_step;
      end
      start = 1'b0; out_valid = 1'b0; out = 2'd0;
      if (!in_valid && iv_cnt > 0 && done_cnt == 0 && mode != M_MUTE && k < 63 && k != drop_at) begin
        j = k / 8 + 1;
        if (mode == M_STAY) out = 2'd0;
        else if (j <= 7 && lane < m_gl[j]) begin out = 2'd1; lane++; end
        else if (j <= 7 && lane > m_gl[j]) begin out = 2'd2; lane--; end
        else if (j <= 7 && (k + 1) % 8 == 0 && m_gt[j] == 2'd1) out = 2'd3;
        else out = 2'd0;
        out_valid = 1'b1;
        if (k == start_at) begin start = 1'b1; seed = 16'h1234; end
        k++;
      end
      @(posedge clk); #1;
    end
    done_after = done;
    start = 1'b0; out_valid = 1'b0; out = 2'd0;
    for (int c = 0; c < 5; c++) begin
      if (done) done_cnt++;
      if (in_valid) iv_extra++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {in_valid, guy, in7, in6, in5, in4, in3, in2, in1, in0,
                       done, pass, err_step, err_code}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_valid", in_valid, 1'b0);

    // Golden responder on seed 1: first gaps are lane 2/road, lane 4/road, lane 0/low, lane 0/high.
    run(16'h0001, M_GOLD, -1, -1);
    chk("t1_iv_cycles", iv_cnt, 64);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_pulse", done_after, 1'b0);
    chk("t1_pass", v_pass, 1'b1);
    chk("t1_code", v_code, 3'd0);
    chk("t1_step", v_step, 6'd0);
    chk("t1_row8_hand", cap[8], 16'hFFCF);
    chk("t1_row16_hand", cap[16], 16'hFCFF);
    chk("t1_row24_hand", cap[24], 16'hFFFD);
    chk("t1_row32_hand", cap[32], 16'hFFFE);
    chk("t1_guy_hand", cap_guy[0], 3'd1);
    check_map("t1");

    run(16'h0001, M_STAY, -1, -1);
    chk("t2_pass", v_pass, 1'b0);
    chk("t2_code", v_code, 3'd1);
    chk("t2_step", v_step, 6'd7);

    run(16'h0001, M_MUTE, -1, -1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_delay", t_done, 300);
    chk("t3_code", v_code, 3'd4);
    chk("t3_step", v_step, 6'd0);
    chk("t3_pass", v_pass, 1'b0);

    run(16'h0001, M_GOLD, 10, -1);
    chk("t4_code", v_code, 3'd5);
    chk("t4_step", v_step, 6'd10);
    chk("t4_pass", v_pass, 1'b0);

    // Abort while row 30 is on the bus, then replay the same seed.
    fill_model(16'h5A5A);
    seed = 16'h5A5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 31; c++) begin
      if (in_valid) begin
        chk($sformatf("t5_pre_row%0d", n), {in7, in6, in5, in4, in3, in2, in1, in0}, row_exp(n));
        n++;
      end
      if (n < 31) begin @(posedge clk); #1; end
    end
    chk("t5_row30_reached", n, 31);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_in_valid", in_valid, 1'b0);
    chk("t5_async_outs", {in_valid, guy, in7, in6, in5, in4, in3, in2, in1, in0,
                          done, pass, err_step, err_code}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'h5A5A, M_GOLD, -1, -1);
    chk("t5_iv_cycles", iv_cnt, 64);
    chk("t5_pass", v_pass, 1'b1);
    check_map("t5");

    // Seed 0 must map to the default seed; a start during CHECK is ignored.
    run(16'h0000, M_GOLD, -1, 20);
    chk("t6_pass", v_pass, 1'b1);
    chk("t6_code", v_code, 3'd0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_no_restart", iv_extra, 0);
    fill_model(16'hACE1);
    check_map("t6_seed0");
    run(16'hACE1, M_GOLD, -1, -1);
    chk("t6_ace1_pass", v_pass, 1'b1);
    check_map("t6_ace1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
